fp_expand: RTL and testbench

Floating-point-to-linear decoder for the 8-bit floating-point format (1-bit sign, 3-bit exponent, 4-bit significand) produced by the conversion and rounding path. It accepts one (S, E, F) word over a valid/ready handshake. It expands the magnitude F·2^E with a one-bit-per-cycle shifter, applies the sign, and presents a 12-bit two's-complement result over a second valid/ready handshake. The block serves as the read-back/verification path for encoded samples.

---
 rtl/fp_expand.sv | 88 ++++++++
 tb/tb_fp_expand.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_expand.sv
// Expands an 8-bit (S,E,F) float to a 12-bit two's-complement value, one shift per cycle.
// Result appears E+1 edges after accept and is held in HOLD until out_ready; no new word is taken while busy.
module fp_expand (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        S,
   input  logic [2:0]  E,
   input  logic [3:0]  F,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] D
);

   typedef enum logic [1:0] {IDLE, SHIFT, FIX, HOLD} state_t;

   state_t      state_q, state_d;
   logic [10:0] mag_q, mag_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        sgn_q, sgn_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [11:0] d_q, d_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mag_q       <= '0;
         cnt_q       <= '0;
         sgn_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         d_q         <= '0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         cnt_q       <= cnt_d;
         sgn_q       <= sgn_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         d_q         <= d_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      cnt_d       = cnt_q;
      sgn_d       = sgn_q;
      out_valid_d = out_valid_q;
      d_d         = d_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               mag_d   = {7'b0, F};
               cnt_d   = E;
               sgn_d   = S;
               state_d = (E != 3'd0) ? SHIFT : FIX;
            end
         end
         SHIFT: begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = FIX;
         end
         FIX: begin
            // Negating zero yields zero, so negative zero cannot be produced.
            d_d         = sgn_q ? (12'd0 - {1'b0, mag_q}) : {1'b0, mag_q};
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign D         = d_q;

endmodule

// File: tb/tb_fp_expand.sv
// Directed-vector bench for fp_expand: latency, sign, zero, backpressure and reset abort.
module tb_fp_expand;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        S = 1'b0;
   logic [2:0]  E = 3'd0;
   logic [3:0]  F = 4'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] D;

   int vec_cnt = 0;
   int err_cnt = 0;
   int lat;
   bit rdy_seen;

   fp_expand dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready), .D(D)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // Called at posedge+1 with in_ready high; returns edges from accept to out_valid (-1 on timeout).
   task automatic send_word(input logic s, input logic [2:0] e, input logic [3:0] f,
                            output int l, output bit seen);
      in_valid = 1'b1; S = s; E = e; F = f;
      @(posedge clk); #1;
      in_valid = 1'b0;
      S = 1'(($urandom) & 1); E = 3'($urandom); F = 4'($urandom);
      l = 0;
      seen = in_ready;
      while (!out_valid && l < 20) begin
         @(posedge clk); #1;
         l++;
         if (!out_valid) seen |= in_ready;
      end
      if (!out_valid) l = -1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vec_cnt++;
      if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL hs_out_valid got %b want 0", out_valid); end
      vec_cnt++;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL hs_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      vec_cnt++;
      if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      vec_cnt++;
      if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      vec_cnt++;
      if (D !== 12'h000) begin err_cnt++; $display("FAIL rst_D got %h want 000", D); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      vec_cnt++;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_e0();
      out_ready = 1'b1;
      send_word(1'b0, 3'd0, 4'b0101, lat, rdy_seen);
      vec_cnt++;
      if (lat !== 1) begin err_cnt++; $display("FAIL e0_latency got %0d want 1", lat); end
      vec_cnt++;
      if (D !== 12'h005) begin err_cnt++; $display("FAIL e0_D got %h want 005", D); end
      vec_cnt++;
      if (rdy_seen !== 1'b0 || in_ready !== 1'b0) begin
         err_cnt++; $display("FAIL e0_in_ready_busy got %b/%b want 0/0", rdy_seen, in_ready);
      end
      handshake();
   endtask

   task automatic test_max();
      send_word(1'b0, 3'd7, 4'b1111, lat, rdy_seen);
      vec_cnt++;
      if (lat !== 8) begin err_cnt++; $display("FAIL max_latency got %0d want 8", lat); end
      vec_cnt++;
      if (D !== 12'h780) begin err_cnt++; $display("FAIL max_D got %h want 780", D); end
      vec_cnt++;
      if (rdy_seen !== 1'b0 || in_ready !== 1'b0) begin
         err_cnt++; $display("FAIL max_in_ready_busy got %b/%b want 0/0", rdy_seen, in_ready);
      end
      handshake();
   endtask

   task automatic test_negative();
      send_word(1'b1, 3'd3, 4'b1010, lat, rdy_seen);
      vec_cnt++;
      if (lat !== 4) begin err_cnt++; $display("FAIL neg80_latency got %0d want 4", lat); end
      vec_cnt++;
      if (D !== 12'hFB0) begin err_cnt++; $display("FAIL neg80_D got %h want fb0", D); end
      handshake();
      send_word(1'b1, 3'd7, 4'b1111, lat, rdy_seen);
      vec_cnt++;
      if (lat !== 8) begin err_cnt++; $display("FAIL negmax_latency got %0d want 8", lat); end
      vec_cnt++;
      if (D !== 12'h880) begin err_cnt++; $display("FAIL negmax_D got %h want 880", D); end
      handshake();
   endtask

   task automatic test_zero();
      send_word(1'b1, 3'd5, 4'b0000, lat, rdy_seen);
      vec_cnt++;
      if (lat !== 6) begin err_cnt++; $display("FAIL zero_latency got %0d want 6", lat); end
      vec_cnt++;
      if (D !== 12'h000) begin err_cnt++; $display("FAIL zero_D got %h want 000", D); end
      handshake();
   endtask

   task automatic test_backpressure();
      send_word(1'b0, 3'd2, 4'b0011, lat, rdy_seen);
      vec_cnt++;
      if (lat !== 3) begin err_cnt++; $display("FAIL bp_latency got %0d want 3", lat); end
      vec_cnt++;
      if (D !== 12'h00C) begin err_cnt++; $display("FAIL bp_D got %h want 00c", D); end
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         S = ~S; E = 3'(i + 1); F = 4'(i * 3 + 1);
         @(posedge clk); #1;
         vec_cnt++;
         if (out_valid !== 1'b1 || D !== 12'h00C || in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_hold_%0d got v=%b D=%h rdy=%b want v=1 D=00c rdy=0", i, out_valid, D, in_ready);
         end
      end
      // Output handshake with a new word already offered: it must wait one edge.
      in_valid = 1'b1; S = 1'b0; E = 3'd1; F = 4'b0101;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vec_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         err_cnt++; $display("FAIL bp_transfer got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      send_word(1'b0, 3'd1, 4'b0101, lat, rdy_seen);
      vec_cnt++;
      if (lat !== 2) begin err_cnt++; $display("FAIL bp_next_latency got %0d want 2", lat); end
      vec_cnt++;
      if (D !== 12'h00A) begin err_cnt++; $display("FAIL bp_next_D got %h want 00a", D); end
      handshake();
   endtask

   task automatic test_reset_mid();
      bit stale;
      in_valid = 1'b1; S = 1'b0; E = 3'd6; F = 4'b1001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || D !== 12'h000) begin
         err_cnt++;
         $display("FAIL rstmid_shift got v=%b rdy=%b D=%h want v=0 rdy=0 D=000", out_valid, in_ready, D);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      vec_cnt++;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_release_in_ready got %b want 1", in_ready); end
      stale = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stale = 1'b1;
      end
      vec_cnt++;
      if (stale !== 1'b0) begin err_cnt++; $display("FAIL rstmid_stale_output got %b want 0", stale); end

      send_word(1'b0, 3'd0, 4'b0011, lat, rdy_seen);
      vec_cnt++;
      if (D !== 12'h003) begin err_cnt++; $display("FAIL rsthold_D got %h want 003", D); end
      #3 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (out_valid !== 1'b0 || D !== 12'h000) begin
         err_cnt++; $display("FAIL rsthold_abort got v=%b D=%h want v=0 D=000", out_valid, D);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      vec_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         err_cnt++; $display("FAIL rsthold_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_e0();
      test_max();
      test_negative();
      test_zero();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
